bram_tree_sched: RTL and testbench

- Multi-client front end for the BRAM tournament-tree priority queue (max at root).
- Round-robin arbitrates push/pop/replace requests from NumReq clients and issues one tree command at a time.
- Holds off the next command until the tree has settled, and tracks occupancy to reject overflow/underflow.
- Returns the removed top item to the issuing client.

---
 rtl/bram_tree_sched.sv | 172 +++++++++++++++++
 tb/tb_bram_tree_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_tree_sched.sv
// bram_tree_sched: round-robin multi-client front end for the BRAM
// tournament-tree priority queue (max at root).
//   CLK, RSTn        : clock, asynchronous active-low reset (shared with tree)
//   i_req/i_op/i_data: per-client request, op (01 push, 10 pop, 11 replace), value
//   o_gnt            : one-hot grant pulse, asserted in the ISSUE cycle
//   o_rsp_*          : response pulse in the cycle after ISSUE (id, reject, top item)
//   o_tree_*         : command strobes/data to the tree; i_tree_data = tree top
//   o_count/o_empty/o_full : occupancy tracking
module bram_tree_sched #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32,
  parameter int QueueSize = 8,
  parameter int OpGap     = 4
) (
  input  logic                           CLK,
  input  logic                           RSTn,
  input  logic [NumReq-1:0]              i_req,
  input  logic [2*NumReq-1:0]            i_op,
  input  logic [NumReq*DataWidth-1:0]    i_data,
  output logic [NumReq-1:0]              o_gnt,
  output logic                           o_rsp_valid,
  output logic [$clog2(NumReq)-1:0]      o_rsp_id,
  output logic                           o_rsp_err,
  output logic [DataWidth-1:0]           o_rsp_data,
  output logic                           o_tree_wrt,
  output logic                           o_tree_read,
  output logic [DataWidth-1:0]           o_tree_data,
  input  logic [DataWidth-1:0]           i_tree_data,
  output logic [$clog2(QueueSize+1)-1:0] o_count,
  output logic                           o_empty,
  output logic                           o_full
);

  localparam int IdW  = $clog2(NumReq);
  localparam int CntW = $clog2(QueueSize+1);
  localparam int GapW = $clog2(OpGap);

  localparam logic [1:0] OpPush = 2'b01;
  localparam logic [1:0] OpPop  = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t           state;
  logic [IdW-1:0]   ptr;
  logic [IdW-1:0]   win_id;
  logic [1:0]       win_op;
  logic             legal;
  logic [GapW-1:0]  gap;

  logic [NumReq-1:0]   elig;
  logic [2*NumReq-1:0] elig2;
  logic [NumReq-1:0]   rot;
  logic                found;
  logic [IdW:0]        sum;
  logic [IdW-1:0]      pick;
  logic [IdW-1:0]      pick_next;
  logic [1:0]          op_pick;
  logic [DataWidth-1:0] data_pick;
  logic                pick_legal;

  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == CntW'(QueueSize));

  // Search is done on the eligibility vector rotated so the RR pointer sits at bit 0.
  always_comb begin
    elig      = '0;
    found     = 1'b0;
    sum       = '0;
    pick      = '0;
    op_pick   = '0;
    data_pick = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      elig[k] = i_req[k] & (i_op[2*k +: 2] != 2'b00);
    end
    elig2 = {elig, elig} >> ptr;
    rot   = elig2[NumReq-1:0];
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IdW+1)'(i);
        if (sum >= (IdW+1)'(NumReq)) begin
          sum = sum - (IdW+1)'(NumReq);
        end
        pick = sum[IdW-1:0];
      end
    end
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (IdW'(k) == pick) begin
        op_pick   = i_op[2*k +: 2];
        data_pick = i_data[k*DataWidth +: DataWidth];
      end
    end
    pick_next  = (pick == IdW'(NumReq-1)) ? '0 : pick + IdW'(1);
    pick_legal = (op_pick == OpPush) ? !o_full : !o_empty;
  end

  // Grant and tree command are registered on the IDLE edge so they appear
  // in the ISSUE cycle; occupancy cannot change while in IDLE.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      ptr         <= '0;
      win_id      <= '0;
      win_op      <= '0;
      legal       <= 1'b0;
      gap         <= '0;
      o_count     <= '0;
      o_gnt       <= '0;
      o_tree_wrt  <= 1'b0;
      o_tree_read <= 1'b0;
      o_tree_data <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_err   <= 1'b0;
      o_rsp_data  <= '0;
    end else begin
      o_gnt       <= '0;
      o_tree_wrt  <= 1'b0;
      o_tree_read <= 1'b0;
      o_tree_data <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_err   <= 1'b0;
      o_rsp_data  <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            win_id <= pick;
            win_op <= op_pick;
            legal  <= pick_legal;
            ptr    <= pick_next;
            o_gnt  <= NumReq'(1) << pick;
            if (pick_legal) begin
              o_tree_wrt  <= op_pick[0];
              o_tree_read <= op_pick[1];
              o_tree_data <= (op_pick == OpPop) ? '0 : data_pick;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          o_rsp_valid <= 1'b1;
          o_rsp_id    <= win_id;
          o_rsp_err   <= !legal;
          if (legal) begin
            if (win_op[1]) begin
              o_rsp_data <= i_tree_data;
            end
            if (win_op == OpPush) begin
              o_count <= o_count + CntW'(1);
            end else if (win_op == OpPop) begin
              o_count <= o_count - CntW'(1);
            end
            gap   <= '0;
            state <= SETTLE;
          end else begin
            state <= IDLE;
          end
        end
        SETTLE: begin
          if (gap == GapW'(OpGap-2)) begin
            state <= IDLE;
          end else begin
            gap <= gap + GapW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_tree_sched.sv
module tb_bram_tree_sched;

  localparam int NumReq    = 4;
  localparam int DataWidth = 32;
  localparam int QueueSize = 8;
  localparam int OpGap     = 4;
  localparam int IdW       = $clog2(NumReq);
  localparam int CntW      = $clog2(QueueSize+1);

  logic                        CLK = 1'b0;
  logic                        RSTn = 1'b0;
  logic [NumReq-1:0]           i_req = '0;
  logic [2*NumReq-1:0]         i_op = '0;
  logic [NumReq*DataWidth-1:0] i_data = '0;
  logic [DataWidth-1:0]        tree_top = '0;
  logic [NumReq-1:0]           o_gnt;
  logic                        o_rsp_valid;
  logic [IdW-1:0]              o_rsp_id;
  logic                        o_rsp_err;
  logic [DataWidth-1:0]        o_rsp_data;
  logic                        o_tree_wrt;
  logic                        o_tree_read;
  logic [DataWidth-1:0]        o_tree_data;
  logic [CntW-1:0]             o_count;
  logic                        o_empty;
  logic                        o_full;

  bram_tree_sched #(
    .NumReq(NumReq), .DataWidth(DataWidth), .QueueSize(QueueSize), .OpGap(OpGap)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .i_req(i_req), .i_op(i_op), .i_data(i_data),
    .o_gnt(o_gnt), .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
    .o_rsp_err(o_rsp_err), .o_rsp_data(o_rsp_data), .o_tree_wrt(o_tree_wrt),
    .o_tree_read(o_tree_read), .o_tree_data(o_tree_data), .i_tree_data(tree_top),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] data;
  } rsp_t;
  rsp_t rq[$];

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] top;
    logic        wrt;
    logic        rd;
    logic [31:0] tdata;
    logic        err;
    logic [31:0] rdata;
    int          cnt;
  } row_t;
  row_t rows[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_rsp(input int id, input logic err, input logic [31:0] data);
    rsp_t r;
    r.id = id; r.err = err; r.data = data;
    rq.push_back(r);
  endtask

  // Scoreboard side: every response pulse must match the oldest expectation.
  always @(negedge CLK) begin : rsp_mon
    rsp_t e;
    if (RSTn && o_rsp_valid) begin
      if (rq.size() == 0) begin
        chk("rsp_unexpected", {o_rsp_id, o_rsp_err}, 64'hFFFF);
      end else begin
        e = rq.pop_front();
        chk("rsp_id", 64'(o_rsp_id), 64'(e.id));
        chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
        chk("rsp_data", 64'(o_rsp_data), 64'(e.data));
      end
    end
  end

  task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] data);
    i_req[id] = 1'b1;
    i_op[2*id +: 2] = op;
    i_data[id*DataWidth +: DataWidth] = data;
  endtask

  task automatic clr_req(input int id);
    i_req[id] = 1'b0;
    i_op[2*id +: 2] = 2'b00;
  endtask

  task automatic wait_gnt(output logic [NumReq-1:0] g, output int n);
    g = '0;
    n = 0;
    while (g == '0 && n < 30) begin
      @(negedge CLK);
      n++;
      g = o_gnt;
    end
    if (g == '0) begin
      total++;
      bad++;
      $display("FAIL gnt_timeout: no grant within %0d cycles", n);
    end
  endtask

  task automatic run_row(input int i);
    logic [NumReq-1:0] g;
    int n;
    row_t r;
    r = rows[i];
    set_req(r.id, r.op, r.data);
    tree_top = r.top;
    wait_gnt(g, n);
    chk($sformatf("row%0d_gnt", i), 64'(g), 64'(1 << r.id));
    chk($sformatf("row%0d_wrt", i), 64'(o_tree_wrt), 64'(r.wrt));
    chk($sformatf("row%0d_read", i), 64'(o_tree_read), 64'(r.rd));
    chk($sformatf("row%0d_tdata", i), 64'(o_tree_data), 64'(r.tdata));
    clr_req(r.id);
    push_rsp(r.id, r.err, r.rdata);
    @(negedge CLK);
    chk($sformatf("row%0d_count", i), 64'(o_count), 64'(r.cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NumReq-1:0] g;
    int n;
    int c0;
    int gc[4];
    logic any;

    //             id op     data    top    wrt rd tdata   err rdata  cnt
    rows[0]  = '{0, 2'b01, 32'd5,   32'd7, 1'b1, 1'b0, 32'd5,   1'b0, 32'd0, 2};
    rows[1]  = '{1, 2'b10, 32'hAA,  32'd7, 1'b0, 1'b1, 32'd0,   1'b0, 32'd7, 1};
    rows[2]  = '{2, 2'b11, 32'd9,   32'd5, 1'b1, 1'b1, 32'd9,   1'b0, 32'd5, 1};
    rows[3]  = '{3, 2'b10, 32'd0,   32'd9, 1'b0, 1'b1, 32'd0,   1'b0, 32'd9, 0};
    rows[4]  = '{0, 2'b10, 32'd1,   32'd3, 1'b0, 1'b0, 32'd0,   1'b1, 32'd0, 0};
    rows[5]  = '{1, 2'b11, 32'd6,   32'd3, 1'b0, 1'b0, 32'd0,   1'b1, 32'd0, 0};
    rows[6]  = '{0, 2'b01, 32'd10,  32'd0, 1'b1, 1'b0, 32'd10,  1'b0, 32'd0, 1};
    rows[7]  = '{1, 2'b01, 32'd20,  32'd10, 1'b1, 1'b0, 32'd20, 1'b0, 32'd0, 2};
    rows[8]  = '{2, 2'b01, 32'd30,  32'd20, 1'b1, 1'b0, 32'd30, 1'b0, 32'd0, 3};
    rows[9]  = '{3, 2'b01, 32'd40,  32'd30, 1'b1, 1'b0, 32'd40, 1'b0, 32'd0, 4};
    rows[10] = '{2, 2'b01, 32'd70,  32'd60, 1'b1, 1'b0, 32'd70, 1'b0, 32'd0, 7};
    rows[11] = '{3, 2'b01, 32'd80,  32'd70, 1'b1, 1'b0, 32'd80, 1'b0, 32'd0, 8};
    rows[12] = '{0, 2'b01, 32'd90,  32'd80, 1'b0, 1'b0, 32'd0,  1'b1, 32'd0, 8};
    rows[13] = '{1, 2'b10, 32'd0,   32'd9, 1'b0, 1'b1, 32'd0,   1'b0, 32'd9, 7};

    // Reset held with random inputs: everything quiet, empty flagged.
    RSTn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1;
      i_req    = NumReq'($urandom);
      i_op     = (2*NumReq)'($urandom);
      i_data   = {$urandom, $urandom, $urandom, $urandom};
      tree_top = $urandom;
      @(negedge CLK);
      chk("rst_ctrl", 64'({o_gnt, o_rsp_valid, o_rsp_id, o_rsp_err, o_tree_wrt,
                           o_tree_read, o_count, o_empty, o_full}), 64'h2);
      chk("rst_data", {o_rsp_data, o_tree_data}, 64'h0);
    end
    i_req = '0; i_op = '0; i_data = '0; tree_top = '0;
    RSTn = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (o_gnt != '0) any = 1'b1;
    end
    chk("idle_no_gnt", 64'(any), 64'h0);

    // Rejected pop from empty, push from client 3 queued behind it.
    set_req(2, 2'b10, 32'd0);
    set_req(3, 2'b01, 32'd33);
    wait_gnt(g, n);
    chk("rej_gnt", 64'(g), 64'h4);
    chk("rej_strobe", 64'({o_tree_wrt, o_tree_read}), 64'h0);
    c0 = cyc;
    clr_req(2);
    push_rsp(2, 1'b1, 32'd0);
    wait_gnt(g, n);
    chk("rej_next_gnt", 64'(g), 64'h8);
    chk("rej_next_gap", 64'(cyc - c0), 64'd2);
    chk("rej_next_wrt", 64'(o_tree_wrt), 64'h1);
    clr_req(3);
    push_rsp(3, 1'b0, 32'd0);
    @(negedge CLK);
    chk("rej_count", 64'(o_count), 64'd1);

    for (int i = 0; i < 6; i++) run_row(i);
    chk("empty_flag", 64'(o_empty), 64'h1);

    // op 00 with req high is never granted.
    set_req(2, 2'b00, 32'd1);
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (o_gnt != '0) any = 1'b1;
    end
    chk("op00_no_gnt", 64'(any), 64'h0);
    clr_req(2);

    for (int i = 6; i < 10; i++) run_row(i);

    // All four replace at once: strict RR order, OpGap+1 cycles apart.
    tree_top = 32'd40;
    for (int k = 0; k < 4; k++) set_req(k, 2'b11, 32'(100 + k));
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g, n);
      gc[k] = cyc;
      chk($sformatf("rr_gnt%0d", k), 64'(g), 64'(1 << k));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 64'(gc[k] - gc[k-1]), 64'd5);
      clr_req(k);
      push_rsp(k, 1'b0, 32'd40);
    end
    @(negedge CLK);
    chk("rr_count", 64'(o_count), 64'd4);

    // Pointer wrapped to 0: client 0 beats client 1.
    tree_top = 32'd50;
    set_req(1, 2'b01, 32'd50);
    set_req(0, 2'b01, 32'd60);
    wait_gnt(g, n);
    chk("wrap_gnt0", 64'(g), 64'h1);
    clr_req(0);
    push_rsp(0, 1'b0, 32'd0);
    wait_gnt(g, n);
    chk("wrap_gnt1", 64'(g), 64'h2);
    clr_req(1);
    push_rsp(1, 1'b0, 32'd0);
    @(negedge CLK);
    chk("wrap_count", 64'(o_count), 64'd6);

    run_row(10);
    run_row(11);
    chk("full_flag", 64'(o_full), 64'h1);
    run_row(12);
    run_row(13);
    chk("not_full", 64'(o_full), 64'h0);

    // Reset during SETTLE of a pop.
    tree_top = 32'd4;
    set_req(2, 2'b10, 32'd0);
    wait_gnt(g, n);
    clr_req(2);
    push_rsp(2, 1'b0, 32'd4);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("mid_rst_ctrl", 64'({o_gnt, o_rsp_valid, o_tree_wrt, o_tree_read, o_count, o_empty}), 64'h1);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;

    // Reset during ISSUE: the pending response is dropped.
    set_req(1, 2'b01, 32'd11);
    wait_gnt(g, n);
    clr_req(1);
    RSTn = 1'b0;
    #1;
    chk("issue_rst", 64'({o_gnt, o_tree_wrt, o_count}), 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("issue_rst_count", 64'(o_count), 64'd0);

    // Fresh push after reset: grant one cycle after the request.
    @(posedge CLK);
    #1;
    set_req(3, 2'b01, 32'd12);
    wait_gnt(g, n);
    chk("post_rst_lat", 64'(n), 64'd2);
    chk("post_rst_gnt", 64'(g), 64'h8);
    clr_req(3);
    push_rsp(3, 1'b0, 32'd0);
    @(negedge CLK);
    chk("post_rst_count", 64'(o_count), 64'd1);

    repeat (10) @(negedge CLK);
    chk("rsp_drain", 64'(rq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
